// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: handshake state encoding,
// vector-table constants agreed with the core, and IRQ-number formatting.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_VECT = 2'd2,
    ST_WAIT = 2'd3
  } irq_state_e;

  // The core branches to IRQ_VECTOR_BASE + IRQ_VECTOR_STRIDE * number.
  localparam logic [15:0] IRQ_VECTOR_BASE   = 16'h0064;
  localparam int          IRQ_VECTOR_STRIDE = 2;

  // Wide enough for up to 16 IRQ lines.
  localparam int IRQ_NUM_W = 4;

  function automatic logic [31:0] irq_num_ext(input logic [IRQ_NUM_W-1:0] num);
    return {28'd0, num};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: index 0 has the highest priority.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0]   I_req,
  output logic [IRQ_NUM_W-1:0] O_sel,
  output logic                 O_any
);

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    O_sel = '0;
    O_any = |I_req;
    // Walk from the top down so the lowest set index is the last to win.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (I_req[i]) O_sel = IRQ_NUM_W'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller feeding the core's IRQ handshake. Define IRQ_CTRL_SYNC_EN
// to insert a 2-flop synchronizer on every IRQ line ahead of edge detection.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int DATA_W  = 16
) (
  input  logic               I_clk,
  input  logic               I_reset,
  input  logic [NUM_IRQ-1:0] I_irq_lines,
  input  logic               I_irq_ack,
  input  logic               I_mask_wr,
  input  logic [NUM_IRQ-1:0] I_mask_in,
  output logic [NUM_IRQ-1:0] O_mask,
  output logic [NUM_IRQ-1:0] O_pending,
  output logic               O_irq_active,
  output logic               O_bus_drive,
  output logic [DATA_W-1:0]  O_bus_data
);

  logic [NUM_IRQ-1:0]   lines_s;
  logic [NUM_IRQ-1:0]   prev_q;
  logic [NUM_IRQ-1:0]   pending_q;
  logic [NUM_IRQ-1:0]   mask_q;
  logic [NUM_IRQ-1:0]   req;
  logic [NUM_IRQ-1:0]   rise;
  logic [NUM_IRQ-1:0]   clr;
  logic [IRQ_NUM_W-1:0] sel;
  logic                 any;
  irq_state_e           state_q;
  logic [IRQ_NUM_W-1:0] num_q;
  logic                 irq_active_q;
  logic                 bus_drive_q;
  logic [DATA_W-1:0]    bus_data_q;

`ifdef IRQ_CTRL_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q;
  logic [NUM_IRQ-1:0] sync2_q;

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values and the two synchronizer stages shift rather than collapse.
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= I_irq_lines;
      sync2_q <= sync1_q;
    end
  end

  assign lines_s = sync2_q;
`else
  assign lines_s = I_irq_lines;
`endif

  assign rise = lines_s & ~prev_q;
  assign req  = pending_q & mask_q;

  irq_prio_enc #(
    .NUM_IRQ(NUM_IRQ)
  ) u_prio_enc (
    .I_req(req),
    .O_sel(sel),
    .O_any(any)
  );

  // The serviced bit is retired at the end of the vector cycle.
  always_comb begin
    clr = '0;
    if (state_q == ST_VECT) begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        clr[i] = (num_q == IRQ_NUM_W'(i));
      end
    end
  end

  // A fresh edge on the bit being cleared wins, so the request is not lost.
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      prev_q    <= '0;
      mask_q    <= '0;
      pending_q <= '0;
    end else begin
      prev_q    <= lines_s;
      pending_q <= (pending_q & ~clr) | rise;
      if (I_mask_wr) mask_q <= I_mask_in;
    end
  end

  // Handshake FSM; outputs are registered alongside the state transition.
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state_q      <= ST_IDLE;
      num_q        <= '0;
      irq_active_q <= 1'b0;
      bus_drive_q  <= 1'b0;
      bus_data_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any) begin
            num_q        <= sel;
            state_q      <= ST_REQ;
            irq_active_q <= 1'b1;
          end
        end
        ST_REQ: begin
          if (I_irq_ack) begin
            state_q      <= ST_VECT;
            irq_active_q <= 1'b0;
            bus_drive_q  <= 1'b1;
            bus_data_q   <= DATA_W'(irq_num_ext(num_q));
          end
        end
        ST_VECT: begin
          state_q     <= ST_WAIT;
          bus_drive_q <= 1'b0;
          bus_data_q  <= '0;
        end
        ST_WAIT: begin
          // A held acknowledge must fall before another request can start.
          if (!I_irq_ack) state_q <= ST_IDLE;
        end
        default: begin
          state_q      <= ST_IDLE;
          irq_active_q <= 1'b0;
          bus_drive_q  <= 1'b0;
          bus_data_q   <= '0;
        end
      endcase
    end
  end

  assign O_mask       = mask_q;
  assign O_pending    = pending_q;
  assign O_irq_active = irq_active_q;
  assign O_bus_drive  = bus_drive_q;
  assign O_bus_data   = bus_data_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed vector table, hand-written
// handshake corner cases, and randomized traffic against a reference model.
module tb_irq_ctrl;

  localparam int NUM_IRQ = 8;
  localparam int DATA_W  = 16;
`ifdef IRQ_CTRL_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic        I_clk = 1'b0;
  logic        I_reset = 1'b1;
  logic [7:0]  lines = '0;
  logic        ack = 1'b0;
  logic        mask_wr = 1'b0;
  logic [7:0]  mask_in = '0;
  logic [7:0]  O_mask;
  logic [7:0]  O_pending;
  logic        O_irq_active;
  logic        O_bus_drive;
  logic [15:0] O_bus_data;

  int checks = 0;
  int errors = 0;

  irq_ctrl #(
    .NUM_IRQ(NUM_IRQ),
    .DATA_W (DATA_W)
  ) dut (
    .I_clk       (I_clk),
    .I_reset     (I_reset),
    .I_irq_lines (lines),
    .I_irq_ack   (ack),
    .I_mask_wr   (mask_wr),
    .I_mask_in   (mask_in),
    .O_mask      (O_mask),
    .O_pending   (O_pending),
    .O_irq_active(O_irq_active),
    .O_bus_drive (O_bus_drive),
    .O_bus_data  (O_bus_data)
  );

  always #5 I_clk = ~I_clk;

  typedef struct {
    logic [7:0]  lines;
    logic        ack;
    logic        mwr;
    logic [7:0]  min;
    logic        act;
    logic        drv;
    logic [15:0] data;
    logic [7:0]  pend;
    logic [7:0]  mask;
  } vec_t;

  vec_t tbl[25];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [33:0] outs();
    return {O_irq_active, O_bus_drive, O_bus_data, O_pending, O_mask};
  endfunction

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  task automatic do_reset();
    I_reset = 1'b1;
    lines   = '0;
    ack     = 1'b0;
    mask_wr = 1'b0;
    mask_in = '0;
    repeat (2) @(posedge I_clk);
    #1;
    I_reset = 1'b0;
  endtask

  task automatic set_mask(input logic [7:0] m);
    mask_wr = 1'b1;
    mask_in = m;
    tick();
    mask_wr = 1'b0;
  endtask

  task automatic pulse(input int b);
    lines[b] = 1'b1;
    tick();
    lines[b] = 1'b0;
  endtask

  task automatic wait_active(input string name);
    int n = 0;
    while (!O_irq_active && n < 20) begin
      tick();
      n++;
    end
    check(name, 64'(O_irq_active), 64'd1);
  endtask

  // Reference model: a set of pending flags, a mask, and one transaction in
  // flight that is either asking, presenting its vector, or draining the ack.
  bit         m_pend[8];
  bit         m_mask[8];
  bit         m_prev[8];
  int         m_srv;
  bit         m_ask, m_vec, m_drain;
  logic [7:0] m_q[$];

  task automatic model_reset();
    foreach (m_pend[i]) begin
      m_pend[i] = 0;
      m_mask[i] = 0;
      m_prev[i] = 0;
    end
    m_srv = 0;
    m_ask = 0;
    m_vec = 0;
    m_drain = 0;
    m_q.delete();
  endtask

  task automatic model_edge(input logic [7:0] l, input logic a, input logic mw,
                            input logic [7:0] mi);
    logic [7:0] s;
    int         low;
    bit         nxt[8];
    m_q.push_back(l);
    s = (m_q.size() > SYNC_LAT) ? m_q.pop_front() : 8'h00;
    low = -1;
    for (int i = 7; i >= 0; i--) if (m_pend[i] && m_mask[i]) low = i;
    for (int i = 0; i < 8; i++)
      nxt[i] = (m_pend[i] && !(m_vec && m_srv == i)) || (s[i] && !m_prev[i]);
    if (m_vec) begin
      m_vec = 0;
      m_drain = 1;
    end else if (m_drain) begin
      if (!a) m_drain = 0;
    end else if (m_ask) begin
      if (a) begin
        m_ask = 0;
        m_vec = 1;
      end
    end else if (low >= 0) begin
      m_srv = low;
      m_ask = 1;
    end
    for (int i = 0; i < 8; i++) begin
      m_pend[i] = nxt[i];
      m_prev[i] = s[i];
      if (mw) m_mask[i] = mi[i];
    end
  endtask

  function automatic logic [33:0] model_outs();
    logic [7:0]  p, m;
    logic [15:0] d;
    for (int i = 0; i < 8; i++) begin
      p[i] = m_pend[i];
      m[i] = m_mask[i];
    end
    d = m_vec ? 16'(m_srv) : 16'h0000;
    return {m_ask, m_vec, d, p, m};
  endfunction

  int n;
  int drives;
  int act_seen;

  initial begin
    //            lines  ack   mwr   min    | act   drv   data      pend   mask
    tbl[0]  = '{8'h00, 1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h04};
    tbl[1]  = '{8'h04, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h04, 8'h04};
    tbl[2]  = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 8'h04, 8'h04};
    tbl[3]  = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0002, 8'h04, 8'h04};
    tbl[4]  = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h04};
    tbl[5]  = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h04};
    tbl[6]  = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h04};
    tbl[7]  = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00};
    tbl[8]  = '{8'h08, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h08, 8'h00};
    tbl[9]  = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h08, 8'h00};
    tbl[10] = '{8'h00, 1'b0, 1'b1, 8'h08, 1'b0, 1'b0, 16'h0000, 8'h08, 8'h08};
    tbl[11] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 8'h08, 8'h08};
    tbl[12] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0003, 8'h08, 8'h08};
    tbl[13] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h08};
    tbl[14] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h08};
    tbl[15] = '{8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 16'h0000, 8'h00, 8'hFF};
    tbl[16] = '{8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h22, 8'hFF};
    tbl[17] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 8'h22, 8'hFF};
    tbl[18] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0001, 8'h22, 8'hFF};
    tbl[19] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h20, 8'hFF};
    tbl[20] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h20, 8'hFF};
    tbl[21] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 8'h20, 8'hFF};
    tbl[22] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0005, 8'h20, 8'hFF};
    tbl[23] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 8'hFF};
    tbl[24] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 8'hFF};

    do_reset();
    check("reset_state", 64'(outs()), 64'd0);

`ifndef IRQ_CTRL_SYNC_EN
    // Cycle-exact table assumes lines are sampled directly.
    foreach (tbl[v]) begin
      lines   = tbl[v].lines;
      ack     = tbl[v].ack;
      mask_wr = tbl[v].mwr;
      mask_in = tbl[v].min;
      tick();
      check($sformatf("vec%0d", v), 64'(outs()),
            64'({tbl[v].act, tbl[v].drv, tbl[v].data, tbl[v].pend, tbl[v].mask}));
    end
    mask_wr = 1'b0;
`endif

    // Request latency, then an asynchronous reset while the request is up.
    do_reset();
    set_mask(8'hFF);
    lines = 8'h40;
    n = 0;
    do begin
      tick();
      n++;
      lines = 8'h00;
    end while (!O_irq_active && n < 20);
    check("irq_latency", 64'(n), 64'(SYNC_LAT + 2));
    #2 I_reset = 1'b1;
    #1 check("async_reset", 64'(outs()), 64'd0);
    tick();
    I_reset = 1'b0;

    // Acknowledge held for 5 cycles while line 0 re-pulses.
    do_reset();
    set_mask(8'h01);
    pulse(0);
    wait_active("hold_req");
    ack = 1'b1;
    drives = 0;
    act_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) lines[0] = 1'b1;
      if (i == 3) lines[0] = 1'b0;
      tick();
      drives += int'(O_bus_drive);
      act_seen += int'(O_irq_active);
    end
    check("hold_one_vector", 64'(drives), 64'd1);
    check("hold_no_rerequest", 64'(act_seen), 64'd0);
    ack = 1'b0;
    tick();
    check("hold_idle_after_release", 64'(O_irq_active), 64'd0);
    tick();
    check("hold_second_req", 64'(O_irq_active), 64'd1);
    ack = 1'b1;
    tick();
    check("hold_second_vector", 64'({O_bus_drive, O_bus_data}), 64'({1'b1, 16'h0000}));
    ack = 1'b0;
    repeat (2) tick();

    // New edge on line 4 lands on the edge that closes its own vector cycle.
    do_reset();
    set_mask(8'h10);
    pulse(4);
    wait_active("reedge_req");
    for (int i = 0; i < SYNC_LAT + 2; i++) begin
      if (i == SYNC_LAT) ack = 1'b1;
      if (i == 1) lines[4] = 1'b1;
      tick();
      if (i == SYNC_LAT)
        check("reedge_vector", 64'({O_bus_drive, O_bus_data}), 64'({1'b1, 16'h0004}));
    end
    check("reedge_pending_kept", 64'(O_pending), 64'h10);
    lines[4] = 1'b0;
    ack = 1'b0;
    repeat (2) tick();
    check("reedge_rerequest", 64'(O_irq_active), 64'd1);
    ack = 1'b1;
    tick();
    check("reedge_second_vector", 64'({O_bus_drive, O_bus_data}), 64'({1'b1, 16'h0004}));
    ack = 1'b0;
    repeat (2) tick();

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) lines[$urandom_range(0, 7)] ^= 1'b1;
      if ($urandom_range(0, 3) == 0) ack = ~ack;
      mask_wr = ($urandom_range(0, 9) == 0);
      mask_in = 8'($urandom);
      tick();
      model_edge(lines, ack, mask_wr, mask_in);
      check($sformatf("rand%0d", c), 64'(outs()), 64'(model_outs()));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
